// File: rtl/z80_bus_tracer.sv
`default_nettype none
// ============================================================================
// z80_bus_tracer : classifies Z80 bus cycles into 32-bit records queued in a
// FIFO drained over valid/ready. Optional TRACER_REFRESH_EN traces refresh.
// Revision: 1.0
// ============================================================================
module z80_bus_tracer #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     trace_en,
  input  logic                     m1_n,
  input  logic                     mreq_n,
  input  logic                     iorq_n,
  input  logic                     rd_n,
  input  logic                     wr_n,
  input  logic                     rfsh_n,
  input  logic [15:0]              A,
  input  logic [7:0]               di,
  input  logic [7:0]               dout,
  output logic                     rec_valid,
  output logic [31:0]              rec_data,
  input  logic                     rec_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [7:0]               drop_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];

  localparam logic [2:0] KIND_FETCH  = 3'd0;
  localparam logic [2:0] KIND_MEMRD  = 3'd1;
  localparam logic [2:0] KIND_MEMWR  = 3'd2;
  localparam logic [2:0] KIND_IORD   = 3'd3;
  localparam logic [2:0] KIND_IOWR   = 3'd4;
  localparam logic [2:0] KIND_INTACK = 3'd6;
`ifdef TRACER_REFRESH_EN
  localparam logic [2:0] KIND_REFRESH = 3'd5;
`else
  logic unused_rfsh;
  assign unused_rfsh = rfsh_n;
`endif

  typedef enum logic {S_IDLE = 1'b0, S_ACTIVE = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [2:0]    kind_q, kind_d;
  logic [4:0]    len_q, len_d;
  logic [15:0]   addr_q, addr_d;
  logic [7:0]    data_q, data_d;

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic [31:0]   head_q, head_d;
  logic          rec_valid_q, rec_valid_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    drop_count_q, drop_count_d;

  logic          cls_valid;
  logic [2:0]    cls_kind;
  logic [7:0]    cap_data;
  logic          start;
  logic          push_req, push, pop, full, drop;
  logic [31:0]   push_rec;

  // Priority classification of the current strobe sample; first match wins.
  always_comb begin
    cls_valid = 1'b1;
    cls_kind  = KIND_FETCH;
    if (!m1_n && !iorq_n)                cls_kind = KIND_INTACK;
    else if (!m1_n && !mreq_n && !rd_n)  cls_kind = KIND_FETCH;
`ifdef TRACER_REFRESH_EN
    else if (!rfsh_n && !mreq_n)         cls_kind = KIND_REFRESH;
`endif
    else if (!mreq_n && !rd_n)           cls_kind = KIND_MEMRD;
    else if (!mreq_n && !wr_n)           cls_kind = KIND_MEMWR;
    else if (!iorq_n && !rd_n)           cls_kind = KIND_IORD;
    else if (!iorq_n && !wr_n)           cls_kind = KIND_IOWR;
    else                                 cls_valid = 1'b0;
  end

  always_comb begin
    cap_data = 8'h00;
    case (cls_kind)
      KIND_FETCH, KIND_MEMRD, KIND_IORD, KIND_INTACK: cap_data = di;
      KIND_MEMWR, KIND_IOWR:                          cap_data = dout;
      default:                                        cap_data = 8'h00;
    endcase
  end

  assign start    = cls_valid && trace_en;
  assign push_rec = {kind_q, len_q, addr_q, data_q};

  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    len_d    = len_q;
    addr_d   = addr_q;
    data_d   = data_q;
    push_req = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ACTIVE;
          kind_d  = cls_kind;
          len_d   = 5'd1;
          addr_d  = A;
          data_d  = cap_data;
        end
      end
      S_ACTIVE: begin
        if (cls_valid && (cls_kind == kind_q)) begin
          if (len_q != 5'd31) len_d = len_q + 5'd1;
          data_d = cap_data;
        end else begin
          // Cycle ended: emit it, and chain straight into the next one if any.
          push_req = 1'b1;
          if (start) begin
            kind_d = cls_kind;
            len_d  = 5'd1;
            addr_d = A;
            data_d = cap_data;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign pop  = rec_ready && (level_q != '0);
  assign full = (level_q == FULL_LEVEL);
  assign push = push_req && (!full || pop);
  assign drop = push_req && full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    // The head register must see a record pushed into an empty (or emptying)
    // FIFO directly, since the memory write lands on the same edge.
    if (level_d == '0)                                      head_d = '0;
    else if ((level_q == '0) || (pop && level_q == 1))      head_d = push_rec;
    else if (pop)                                           head_d = mem_q[rd_ptr_d];
    else                                                    head_d = head_q;
    rec_valid_d  = (level_d != '0);
    overflow_d   = overflow_q | drop;
    drop_count_d = (drop && drop_count_q != 8'hFF) ? drop_count_q + 8'd1 : drop_count_q;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_rec;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      kind_q       <= '0;
      len_q        <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      head_q       <= '0;
      rec_valid_q  <= 1'b0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      kind_q       <= kind_d;
      len_q        <= len_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      head_q       <= head_d;
      rec_valid_q  <= rec_valid_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign rec_valid  = rec_valid_q;
  assign rec_data   = head_q;
  assign level      = level_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule
`default_nettype wire
